// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the hazard/forwarding controller.
//   REG_ADDR_W_DEF : default register index width
//   FWD_REGFILE    : fwd_sel encoding meaning "operand comes from the register file"
//   slot_t         : one in-flight writer entry {valid, rd, is_load}
package core_pkg;

   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned FWD_REGFILE    = 0;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_W_DEF-1:0] rd;
      logic                      is_load;
   } slot_t;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: forwarding-source search for one source operand.
// Ports:
//   slots_i       in  scoreboard, slot 0 = instruction now in EX (youngest)
//   rs_i          in  source register index read by ID
//   fwd_sel_o     out 0 = register file, k+1 = result of slot k
//   load_hazard_o out youngest match is a load whose data is not yet forwardable
module hazard_match
   import core_pkg::*;
#(
   parameter int unsigned FWD_DEPTH = 3,
   parameter int unsigned LOAD_LAT  = 2,
   parameter int unsigned SEL_W     = 2
) (
   input  slot_t [FWD_DEPTH-1:0] slots_i,
   input  logic [REG_ADDR_W_DEF-1:0] rs_i,
   output logic [SEL_W-1:0]          fwd_sel_o,
   output logic                      load_hazard_o
);

   logic found;

   // Priority search from the youngest slot; the first hit wins so older
   // writers to the same register are shadowed.
   always_comb begin
      found         = 1'b0;
      fwd_sel_o     = SEL_W'(FWD_REGFILE);
      load_hazard_o = 1'b0;
      for (int i = 0; i < int'(FWD_DEPTH); i++) begin
         if (!found && slots_i[i].valid && (slots_i[i].rd == rs_i) && (rs_i != '0)) begin
            found         = 1'b1;
            fwd_sel_o     = SEL_W'(i + 1);
            load_hazard_o = slots_i[i].is_load && (i < int'(LOAD_LAT) - 1);
         end
      end
   end

endmodule

// File: rtl/pipe_hazard.sv
// pipe_hazard: hazard, forwarding and branch-squash controller between ID and EX.
// Tracks FWD_DEPTH in-flight writers in a shift-register scoreboard, selects
// forwarding sources for both operands, stalls ID on load-use and squashes
// FLUSH_DEPTH issue slots after an accepted taken branch/jump.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_rs1/id_rs2/id_rd   ID register indices
//   id_regwrite           ID instruction writes id_rd
//   id_is_load            ID instruction is a load
//   ex_branch_taken       EX resolves a taken branch/jump
//   issue                 ID instruction advances to EX at the next edge
//   stall                 hold PC and ID; bubble into EX
//   flush                 ID contents are wrong-path; bubble into EX
//   fwd_sel1/fwd_sel2     0 = register file, k+1 = result of slot k
//   stall_cnt/flush_cnt_o cycle counters, present only with HAZARD_PERF_EN defined
// REG_ADDR_W must equal core_pkg::REG_ADDR_W_DEF (slot_t is sized by the package).
module pipe_hazard
   import core_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int unsigned FWD_DEPTH   = 3,
   parameter int unsigned LOAD_LAT    = 2,
   parameter int unsigned FLUSH_DEPTH = 2,
   localparam int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_is_load,
   input  logic                  ex_branch_taken,
   output logic                  issue,
   output logic                  stall,
   output logic                  flush,
   output logic [SEL_W-1:0]      fwd_sel1,
   output logic [SEL_W-1:0]      fwd_sel2
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt_o
`endif
);

   localparam int unsigned CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

   slot_t [FWD_DEPTH-1:0] slots_q, slots_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

   logic [SEL_W-1:0] sel1, sel2;
   logic             lh1, lh2;
   logic             branch_acc;
   logic             flush_raw, stall_raw, issue_raw;

   hazard_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
   ) u_match_rs1 (
      .slots_i       (slots_q),
      .rs_i          (id_rs1),
      .fwd_sel_o     (sel1),
      .load_hazard_o (lh1)
   );

   hazard_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
   ) u_match_rs2 (
      .slots_i       (slots_q),
      .rs_i          (id_rs2),
      .fwd_sel_o     (sel2),
      .load_hazard_o (lh2)
   );

   // A taken branch seen while squashing is itself wrong-path and is dropped.
   always_comb begin
      branch_acc = ex_branch_taken & (flush_cnt_q == '0);
      flush_raw  = branch_acc | (flush_cnt_q != '0);
      stall_raw  = id_valid & (lh1 | lh2) & ~flush_raw;
      issue_raw  = id_valid & ~stall_raw & ~flush_raw;
   end

   // Outputs are held quiet for the whole time reset is asserted.
   always_comb begin
      issue    = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      fwd_sel1 = SEL_W'(FWD_REGFILE);
      fwd_sel2 = SEL_W'(FWD_REGFILE);
      if (!rst) begin
         issue    = issue_raw;
         stall    = stall_raw;
         flush    = flush_raw;
         fwd_sel1 = sel1;
         fwd_sel2 = sel2;
      end
   end

   // Scoreboard shift; x0 writers never enter as valid so they cannot match.
   always_comb begin
      slots_d    = slots_q;
      slots_d[0] = '{valid:   issue & id_regwrite & (id_rd != '0),
                     rd:      id_rd,
                     is_load: id_is_load};
      for (int i = 1; i < int'(FWD_DEPTH); i++) begin
         slots_d[i] = slots_q[i-1];
      end
   end

   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (branch_acc) begin
         flush_cnt_d = CNT_W'(FLUSH_DEPTH - 1);
      end else if (flush_cnt_q != '0) begin
         flush_cnt_d = flush_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots_q     <= '0;
         flush_cnt_q <= '0;
      end else begin
         slots_q     <= slots_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cyc_q, flush_cyc_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall};
      flush_cyc_d = flush_cyc_q + {31'd0, flush};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cyc_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cyc_q <= flush_cyc_d;
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt_o = flush_cyc_q;
`endif

endmodule

// File: doc/pipe_hazard.md
# pipe_hazard

Parametrised hazard, forwarding and branch-squash controller for the pipelined integer core. It generalises the core's fixed two-stage branch mask and single-stage register forwarding. It tracks up to FWD_DEPTH in-flight register writers in a shift-register scoreboard and selects forwarding sources for both source operands. It stalls ID on load-use hazards and squashes a configurable number of wrong-path issue slots after a taken branch or jump. It sits between decode (ID) and execute (EX) and drives the operand muxes and pipeline-register enables.

## Interface
- REG_ADDR_W, 5: register index width.
- FWD_DEPTH, 3: in-flight writer slots (EX..WB); slot 0 = instruction now in EX.
- LOAD_LAT, 2: slots a load occupies before its data is forwardable; 1 ≤ LOAD_LAT ≤ FWD_DEPTH.
- FLUSH_DEPTH, 2: issue slots squashed per taken branch, counting the ID slot of the branch cycle; ≥ 1.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  source and destination indices of the ID instruction.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load (integer or FPU-to-int transfer).
- ex_branch_taken  in  1  EX resolves a taken branch or jump this cycle.
- issue  out  1  ID instruction advances to EX at the next edge.
- stall  out  1  hold PC and the ID register; EX receives a bubble.
- flush  out  1  ID contents are wrong-path; EX receives a bubble.
- fwd_sel1, fwd_sel2  out  $clog2(FWD_DEPTH+1)  0 = register file, k+1 = result of slot k.

## Operation
- Scoreboard: each slot holds {valid, rd, is_load}. Every edge, slot[i+1] ← slot[i] and slot[FWD_DEPTH-1] retires. slot[0] ← {issue & id_regwrite & (id_rd≠0), id_rd, id_is_load}.
- Match on rs (per operand): the youngest valid slot k with rd == rs. rs == 0 never matches. If there is no match, fwd_sel = 0. Otherwise fwd_sel = k+1.
- Load-use: if the youngest match is a load with k < LOAD_LAT-1, the hazard is raised. Older matches are ignored.
- Branch accepted: branch_acc = ex_branch_taken & (flush_cnt == 0). ex_branch_taken is ignored while flush_cnt ≠ 0, because that branch is itself wrong-path.
- On branch_acc, flush_cnt ← FLUSH_DEPTH-1.
- While flush_cnt ≠ 0, flush_cnt decrements by 1 each edge.
- flush = branch_acc | (flush_cnt ≠ 0).
- stall = id_valid & hazard & ~flush. Flush overrides stall.
- issue = id_valid & ~stall & ~flush.

## Timing
- stall, flush, issue and fwd_sel are combinational from the current inputs and scoreboard state. There is no added latency.
- The scoreboard and flush_cnt update on the rising edge of clk.
- Branch accepted in cycle t: flush is high in cycles t .. t+FLUSH_DEPTH-1. A branch at t+1 is ignored when FLUSH_DEPTH ≥ 2.
- Stall: repeats every cycle until the producing load reaches slot LOAD_LAT-1. With the defaults this is exactly one bubble.
- Reset (asynchronous, at any point including mid-flush or mid-stall):
  - all slots invalid, flush_cnt = 0, performance counters = 0.
  - while rst is high, stall, flush, issue and fwd_sel1/2 are forced to 0.
- Back-to-back writers to the same rd: the youngest wins.
- A slot that is a bubble (invalid) never matches.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt_o[31:0].
  - each counts cycles in which stall (respectively flush) is high.
  - both wrap at 2^32 and are cleared by rst.
- HAZARD_PERF_EN undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package core_pkg:
  - slot_t typedef {valid, rd, is_load}.
  - REG_ADDR_W default.
  - fwd_sel encoding constant FWD_REGFILE = 0.
- One sub-module, hazard_match, instantiated once per source operand.
  - inputs: the slot vector and rs.
  - outputs: fwd_sel and load_hazard.
  - implemented as a priority search from slot 0 upward.

## Test plan
- Defaults. Issue add x5 (regwrite), then ID reads rs1=x5 → fwd_sel1=1. Next cycle, ID reads x5 → fwd_sel1=2.
- Issue lw x7, then ID reads rs2=x7 → stall=1 and issue=0 for one cycle. The next cycle gives fwd_sel2=2 and stall=0.
- ex_branch_taken=1 in cycle t and again in t+1 → flush=1 in t and t+1 only, issue=0 in both, flush_cnt returns to 0. The second branch is ignored.
- ID reads rs1=x0 while slot 0 has rd=x0 and regwrite=1 → fwd_sel1=0, no stall.
- Load-use stall coinciding with ex_branch_taken → flush=1, stall=0. The load entry still ages normally.
- Assert rst mid-flush with slots valid → outputs are 0 immediately. After release, a read of the old rd gives fwd_sel=0. With HAZARD_PERF_EN, stall_cnt=0.
